// File: rtl/mem_access_sequencer.sv
// Multi-cycle sequencer that shares one single-ported memory between instruction fetch and data access.
// Also provides the wait-state watchdog, halting-opcode decode and the retired-instruction counter.
module mem_access_sequencer #(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic             mem_read_req,
  input  logic             mem_write_req,
  input  logic             regwrite_in,
  input  logic             mem_ready,
  output logic             mem_en,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_write,
  output logic             rf_we,
  output logic             halted,
  output logic             error,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    WB    = 3'd4,
    HALT  = 3'd5,
    ERR   = 3'd6
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

  state_t              state_reg;
  logic [WAIT_W-1:0]   wait_cnt_reg;
  logic [CNT_W-1:0]    instret_reg;

  logic halt_op;
  logic mem_op;

  // FENCE family (MISC-MEM) and SYSTEM opcodes stop the core.
  assign halt_op = (opcode == 5'b00011) || (opcode == 5'b11100);
  assign mem_op  = mem_read_req || mem_write_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      instret_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= FETCH;
          wait_cnt_reg <= '0;
        end
        FETCH, MEM: begin
          // A completion on the last allowed wait cycle still wins over the timeout.
          if (mem_ready)
            state_reg <= (state_reg == FETCH) ? EXEC : WB;
          else if (wait_cnt_reg == MAX_WAIT_C)
            state_reg <= ERR;
          else
            wait_cnt_reg <= wait_cnt_reg + WAIT_W'(1);
        end
        EXEC: begin
          if (halt_op) begin
            state_reg <= HALT;
          end else if (mem_op) begin
            state_reg    <= MEM;
            wait_cnt_reg <= '0;
          end else begin
            state_reg    <= FETCH;
            wait_cnt_reg <= '0;
            instret_reg  <= instret_reg + CNT_W'(1);
          end
        end
        WB: begin
          state_reg    <= FETCH;
          wait_cnt_reg <= '0;
          instret_reg  <= instret_reg + CNT_W'(1);
        end
        HALT:    state_reg <= HALT;
        ERR:     state_reg <= ERR;
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_load      = 1'b0;
    pc_write     = 1'b0;
    rf_we        = 1'b0;
    halted       = 1'b0;
    error        = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_en  = 1'b1;
        ir_load = mem_ready;
      end
      EXEC: begin
        pc_write = !halt_op && !mem_op;
        rf_we    = !halt_op && !mem_op && regwrite_in;
      end
      MEM: begin
        mem_en       = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = mem_write_req;
      end
      WB: begin
        pc_write = 1'b1;
        rf_we    = regwrite_in;
      end
      HALT:    halted = 1'b1;
      ERR:     error  = 1'b1;
      default: ;
    endcase
  end

  assign state   = state_reg;
  assign instret = instret_reg;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed table-driven bench for mem_access_sequencer plus hand-written multi-cycle sequences.
module tb_mem_access_sequencer;

  logic        clk;
  logic        rst;
  logic [4:0]  opcode;
  logic        mem_read_req;
  logic        mem_write_req;
  logic        regwrite_in;
  logic        mem_ready;
  logic        mem_en;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        ir_load;
  logic        pc_write;
  logic        rf_we;
  logic        halted;
  logic        error;
  logic [2:0]  state;
  logic [31:0] instret;

  int checks = 0;
  int errors = 0;

  localparam logic [4:0] OP_ADD = 5'b01100;
  localparam logic [4:0] OP_LW  = 5'b00000;
  localparam logic [4:0] OP_SW  = 5'b01000;
  localparam logic [4:0] OP_SYS = 5'b11100;

  // strobe vector order: mem_en, mem_we, mem_addr_sel, ir_load, pc_write, rf_we, halted, error
  localparam logic [7:0] S_NONE  = 8'b0000_0000;
  localparam logic [7:0] S_FETCH = 8'b1001_0000;
  localparam logic [7:0] S_RD    = 8'b1010_0000;
  localparam logic [7:0] S_WR    = 8'b1110_0000;
  localparam logic [7:0] S_COMW  = 8'b0000_1100;
  localparam logic [7:0] S_COM   = 8'b0000_1000;
  localparam logic [7:0] S_HALT  = 8'b0000_0010;

  typedef struct {
    logic        r;
    logic [4:0]  op;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        rdy;
    logic [2:0]  st;
    logic [7:0]  sb;
    logic [31:0] ir;
  } vec_t;

  vec_t tbl[19];

  mem_access_sequencer #(.CNT_W(32), .MAX_WAIT(15), .WAIT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .regwrite_in(regwrite_in), .mem_ready(mem_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_load(ir_load),
    .pc_write(pc_write), .rf_we(rf_we), .halted(halted), .error(error),
    .state(state), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic [4:0] op, logic rd, logic wr, logic rw,
                              logic rdy, logic [2:0] st, logic [7:0] sb, logic [31:0] ir);
    vec_t v;
    v.r = r; v.op = op; v.rd = rd; v.wr = wr; v.rw = rw; v.rdy = rdy;
    v.st = st; v.sb = sb; v.ir = ir;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic r, input logic [4:0] op, input logic rd, input logic wr,
                       input logic rw, input logic rdy);
    rst = r; opcode = op; mem_read_req = rd; mem_write_req = wr;
    regwrite_in = rw; mem_ready = rdy;
  endtask

  function automatic logic [7:0] strobes();
    return {mem_en, mem_we, mem_addr_sel, ir_load, pc_write, rf_we, halted, error};
  endfunction

  initial begin
    int n;
    // reset, ADD, LW with 3 wait cycles, SW, ECALL into HALT
    tbl[0]  = mk(0, OP_ADD, 0, 0, 1, 1, 3'd0, S_NONE,  0);
    tbl[1]  = mk(1, OP_ADD, 0, 0, 1, 1, 3'd0, S_NONE,  0);
    tbl[2]  = mk(1, OP_ADD, 0, 0, 1, 1, 3'd1, S_FETCH, 0);
    tbl[3]  = mk(1, OP_ADD, 0, 0, 1, 1, 3'd2, S_COMW,  0);
    tbl[4]  = mk(1, OP_LW,  1, 0, 1, 1, 3'd1, S_FETCH, 1);
    tbl[5]  = mk(1, OP_LW,  1, 0, 1, 1, 3'd2, S_NONE,  1);
    tbl[6]  = mk(1, OP_LW,  1, 0, 1, 0, 3'd3, S_RD,    1);
    tbl[7]  = mk(1, OP_LW,  1, 0, 1, 0, 3'd3, S_RD,    1);
    tbl[8]  = mk(1, OP_LW,  1, 0, 1, 0, 3'd3, S_RD,    1);
    tbl[9]  = mk(1, OP_LW,  1, 0, 1, 1, 3'd3, S_RD,    1);
    tbl[10] = mk(1, OP_LW,  1, 0, 1, 1, 3'd4, S_COMW,  1);
    tbl[11] = mk(1, OP_SW,  0, 1, 0, 1, 3'd1, S_FETCH, 2);
    tbl[12] = mk(1, OP_SW,  0, 1, 0, 1, 3'd2, S_NONE,  2);
    tbl[13] = mk(1, OP_SW,  0, 1, 0, 1, 3'd3, S_WR,    2);
    tbl[14] = mk(1, OP_SW,  0, 1, 0, 1, 3'd4, S_COM,   2);
    tbl[15] = mk(1, OP_SYS, 0, 0, 1, 1, 3'd1, S_FETCH, 3);
    tbl[16] = mk(1, OP_SYS, 0, 0, 1, 1, 3'd2, S_NONE,  3);
    tbl[17] = mk(1, OP_SYS, 0, 0, 1, 1, 3'd5, S_HALT,  3);
    tbl[18] = mk(1, OP_SYS, 1, 1, 1, 1, 3'd5, S_HALT,  3);

    drive(0, OP_ADD, 0, 0, 1, 1);
    repeat (2) tick;

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r, tbl[i].op, tbl[i].rd, tbl[i].wr, tbl[i].rw, tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_strobes", i), 32'(strobes()), 32'(tbl[i].sb));
      chk($sformatf("vec%0d_instret", i), instret, tbl[i].ir);
      $display("vec %0d: state=%0d strobes=%b instret=%0d", i, state, strobes(), instret);
      tick;
    end

    // HALT is sticky while mem_ready stays high
    drive(1, OP_ADD, 0, 0, 1, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (state !== 3'd5 || halted !== 1'b1 || mem_en !== 1'b0 || instret !== 32'd3) n++;
      tick;
    end
    chk("halt_sticky_bad_cycles", 32'(n), 0);
    $display("halt hold: bad cycles=%0d", n);

    drive(0, OP_ADD, 0, 0, 1, 1);
    tick;
    drive(1, OP_ADD, 0, 0, 1, 0);
    #1;
    chk("halt_reset_state", 32'(state), 0);
    chk("halt_reset_halted", 32'(halted), 0);
    chk("halt_reset_instret", instret, 0);
    $display("reset from halt: state=%0d halted=%0d", state, halted);

    // fetch timeout: 16 cycles in FETCH, then sticky ERR
    tick;
    n = 0;
    for (int i = 0; i < 40 && state == 3'd1; i++) begin
      n++;
      tick;
    end
    #1;
    chk("timeout_fetch_cycles", 32'(n), 16);
    chk("timeout_state", 32'(state), 6);
    chk("timeout_strobes", 32'(strobes()), 32'h01);
    $display("timeout: fetch cycles=%0d state=%0d", n, state);
    mem_ready = 1'b1;
    repeat (5) tick;
    #1;
    chk("err_sticky_state", 32'(state), 6);
    chk("err_sticky_strobes", 32'(strobes()), 32'h01);

    // reset in the middle of a MEM wait
    drive(0, OP_ADD, 0, 0, 1, 1);
    tick;
    drive(1, OP_ADD, 0, 0, 1, 1);
    repeat (3) tick;
    drive(1, OP_LW, 1, 0, 1, 1);
    repeat (2) tick;
    mem_ready = 1'b0;
    repeat (2) tick;
    #1;
    chk("midmem_state", 32'(state), 3);
    chk("midmem_instret", instret, 1);
    rst = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    chk("midmem_reset_state", 32'(state), 0);
    chk("midmem_reset_mem_en", 32'(mem_en), 0);
    chk("midmem_reset_instret", instret, 0);
    tick;
    #1;
    chk("midmem_resume_state", 32'(state), 1);
    chk("midmem_resume_mem_en", 32'(mem_en), 1);
    $display("mid-MEM reset: resumed state=%0d", state);

    // completion on the last allowed wait cycle is accepted
    repeat (15) tick;
    #1;
    chk("lastwait_state", 32'(state), 1);
    mem_ready = 1'b1;
    #1;
    chk("lastwait_ir_load", 32'(ir_load), 1);
    tick;
    #1;
    chk("lastwait_exec", 32'(state), 2);
    $display("last-wait accept: state=%0d", state);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
